// File: rtl/dtpu_stream_adapter.sv
// dtpu_stream_adapter
//   Datapath sequencer between the input/output data FIFOs, the weight BRAM
//   and the MXU. A job loads one M x K weight tile (one BRAM word per row),
//   streams vec_count input vectors through the MXU and pushes the M-lane
//   results into the output FIFO through a small credit-managed result buffer.
//
//   Ports:
//     clk, reset           single clock, synchronous active-high reset
//     start, vec_count,    job launch (accepted in IDLE only), vector count
//     wm_base              and weight-tile byte address, latched on start
//     busy, done           not-IDLE flag, one-cycle completion pulse
//     wm_address/ce/we,    weight BRAM read port (1-cycle read latency)
//     wm_dout
//     infifo_*             input FIFO pop side (first-word-fall-through)
//     outfifo_*            output FIFO push side
//     mxu_enable/input/    MXU clock enable, operand lanes, weight bank,
//     mxu_weight, mxu_y    and result lanes
//     stall_cycles         STREAM stall counter
//
//   Build option: define DTPU_STALL_CNT_EN to build the stall counter;
//   otherwise stall_cycles is tied to 0.
module dtpu_stream_adapter #(
    parameter int ROWS           = 3,
    parameter int COLUMNS        = 3,
    parameter int DATA_WIDTH_MAC = 4,
    parameter int MXU_LATENCY    = 2,
    parameter int OBUF_DEPTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [15:0]                            vec_count,
    input  logic [31:0]                            wm_base,
    output logic                                   busy,
    output logic                                   done,
    output logic [31:0]                            wm_address,
    output logic                                   wm_ce,
    output logic                                   wm_we,
    input  logic [63:0]                            wm_dout,
    input  logic [63:0]                            infifo_dout,
    input  logic                                   infifo_is_empty,
    output logic                                   infifo_read,
    output logic [63:0]                            outfifo_din,
    input  logic                                   outfifo_is_full,
    output logic                                   outfifo_write,
    output logic                                   mxu_enable,
    output logic [COLUMNS*DATA_WIDTH_MAC-1:0]      mxu_input,
    output logic [ROWS*COLUMNS*DATA_WIDTH_MAC-1:0] mxu_weight,
    input  logic [ROWS*DATA_WIDTH_MAC-1:0]         mxu_y,
    output logic [31:0]                            stall_cycles
);
    localparam int M     = ROWS;
    localparam int KW    = COLUMNS * DATA_WIDTH_MAC;
    localparam int MW    = ROWS * DATA_WIDTH_MAC;
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = $clog2(M + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         vec_rem_q, vec_rem_d;
    logic [31:0]         wm_base_q, wm_base_d;
    logic [ROW_W-1:0]    rd_row_q, rd_row_d;
    logic [ROW_W-1:0]    cap_row_q, cap_row_d;
    logic                rd_pend_q, rd_pend_d;
    logic [M*KW-1:0]     weight_q, weight_d;
    logic [KW-1:0]       mxu_input_q, mxu_input_d;
    logic [MXU_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [PTR_W-1:0]    obuf_wr_ptr_q, obuf_wr_ptr_d;
    logic [PTR_W-1:0]    obuf_rd_ptr_q, obuf_rd_ptr_d;
    logic [CNT_W-1:0]    obuf_cnt_q, obuf_cnt_d;
    logic [MW-1:0]       obuf_mem [OBUF_DEPTH];

    logic [CNT_W-1:0]    inflight_c;
    logic [CNT_W:0]      credit_used_c;
    logic                wm_ce_c, issue_c, mxu_en_c, obuf_wr_c, obuf_rd_c;
    logic                unused_bits;

    // Upper bus bits beyond the packed lanes are intentionally ignored.
    assign unused_bits = ^{wm_dout, infifo_dout};

    // Results in flight inside the MXU pipeline.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < MXU_LATENCY; i++) begin
            inflight_c = inflight_c + CNT_W'(vld_sr_q[i]);
        end
    end

    // An issue is allowed only when every in-flight and buffered result is
    // guaranteed a buffer slot, so the result buffer can never overflow.
    assign credit_used_c = {1'b0, inflight_c} + {1'b0, obuf_cnt_q};
    assign issue_c   = (state_q == S_STREAM) && !infifo_is_empty &&
                       (credit_used_c < (CNT_W + 1)'(OBUF_DEPTH));
    assign wm_ce_c   = (state_q == S_LOAD_W) && (rd_row_q < ROW_W'(M));
    assign mxu_en_c  = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                       ((|vld_sr_q) || issue_c);
    assign obuf_wr_c = mxu_en_c && vld_sr_q[MXU_LATENCY-1];
    assign obuf_rd_c = (obuf_cnt_q != '0) && !outfifo_is_full;

    // Sequencer: state, job counters and weight-tile capture.
    always_comb begin
        state_d   = state_q;
        vec_rem_d = vec_rem_q;
        wm_base_d = wm_base_q;
        rd_row_d  = rd_row_q;
        cap_row_d = cap_row_q;
        rd_pend_d = 1'b0;
        weight_d  = weight_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD_W;
                    vec_rem_d = vec_count;
                    wm_base_d = wm_base;
                    rd_row_d  = '0;
                    cap_row_d = '0;
                end
            end
            S_LOAD_W: begin
                rd_pend_d = wm_ce_c;
                if (wm_ce_c) begin
                    rd_row_d = rd_row_q + 1'b1;
                end
                // BRAM data arrives one cycle after its read was issued.
                if (rd_pend_q) begin
                    for (int r = 0; r < M; r++) begin
                        if (ROW_W'(r) == cap_row_q) begin
                            weight_d[r*KW +: KW] = wm_dout[KW-1:0];
                        end
                    end
                    cap_row_d = cap_row_q + 1'b1;
                    if (cap_row_q == ROW_W'(M - 1)) begin
                        state_d = (vec_rem_q == 16'd0) ? S_DRAIN : S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (issue_c) begin
                    vec_rem_d = vec_rem_q - 16'd1;
                    if (vec_rem_q == 16'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_c == '0) && (obuf_cnt_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand register, MXU valid pipeline and result-buffer pointers.
    always_comb begin
        mxu_input_d   = issue_c ? infifo_dout[KW-1:0] : mxu_input_q;
        vld_sr_d      = vld_sr_q;
        if (mxu_en_c) begin
            vld_sr_d    = vld_sr_q << 1;
            vld_sr_d[0] = issue_c;
        end
        obuf_wr_ptr_d = obuf_wr_ptr_q + PTR_W'(obuf_wr_c);
        obuf_rd_ptr_d = obuf_rd_ptr_q + PTR_W'(obuf_rd_c);
        obuf_cnt_d    = obuf_cnt_q + CNT_W'(obuf_wr_c) - CNT_W'(obuf_rd_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vec_rem_q     <= '0;
            wm_base_q     <= '0;
            rd_row_q      <= '0;
            cap_row_q     <= '0;
            rd_pend_q     <= 1'b0;
            weight_q      <= '0;
            mxu_input_q   <= '0;
            vld_sr_q      <= '0;
            obuf_wr_ptr_q <= '0;
            obuf_rd_ptr_q <= '0;
            obuf_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            vec_rem_q     <= vec_rem_d;
            wm_base_q     <= wm_base_d;
            rd_row_q      <= rd_row_d;
            cap_row_q     <= cap_row_d;
            rd_pend_q     <= rd_pend_d;
            weight_q      <= weight_d;
            mxu_input_q   <= mxu_input_d;
            vld_sr_q      <= vld_sr_d;
            obuf_wr_ptr_q <= obuf_wr_ptr_d;
            obuf_rd_ptr_q <= obuf_rd_ptr_d;
            obuf_cnt_q    <= obuf_cnt_d;
        end
    end

    // Result storage; validity is tracked by the pointers, not the contents.
    always_ff @(posedge clk) begin
        if (obuf_wr_c) begin
            obuf_mem[obuf_wr_ptr_q] <= mxu_y;
        end
    end

`ifdef DTPU_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == S_STREAM) && !issue_c && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign wm_ce         = wm_ce_c;
    assign wm_we         = 1'b0;
    assign wm_address    = wm_ce_c ? (wm_base_q + 32'({rd_row_q, 3'b000})) : 32'd0;
    assign infifo_read   = issue_c;
    assign outfifo_write = obuf_rd_c;
    assign outfifo_din   = (obuf_cnt_q != '0) ? 64'(obuf_mem[obuf_rd_ptr_q]) : 64'd0;
    assign mxu_enable    = mxu_en_c;
    assign mxu_input     = mxu_input_q;
    assign mxu_weight    = weight_q;

endmodule

// File: tb/tb_dtpu_stream_adapter.sv
module tb_dtpu_stream_adapter;
    localparam int M  = 3;
    localparam int K  = 3;
    localparam int DW = 4;
    localparam int KW = K * DW;
    localparam int MW = M * DW;
    localparam int OBUF_DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     vec_count = 16'd0;
    logic [31:0]     wm_base = 32'd0;
    logic            busy, done;
    logic [31:0]     wm_address;
    logic            wm_ce, wm_we;
    logic [63:0]     wm_dout = 64'd0;
    logic [63:0]     infifo_dout;
    logic            infifo_is_empty;
    logic            infifo_read;
    logic [63:0]     outfifo_din;
    logic            outfifo_is_full = 1'b0;
    logic            outfifo_write;
    logic            mxu_enable;
    logic [KW-1:0]   mxu_input;
    logic [M*KW-1:0] mxu_weight;
    logic [MW-1:0]   mxu_y = '0;
    logic [31:0]     stall_cycles;

    int checks = 0;
    int errors = 0;

    // Input FIFO model
    logic [63:0] in_mem [32];
    int          in_wr = 0;
    int          in_rd = 0;
    logic        empty_gate = 1'b0;
    logic        in_flush = 1'b0;

    // Monitor results
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          rd_n = 0;
    int          out_n = 0;
    int          wa_n = 0;
    int          viol = 0;
    int          obuf_max = 0;
    logic [63:0] out_log [32];
    logic [31:0] wa_log [8];

    dtpu_stream_adapter #(
        .ROWS(M), .COLUMNS(K), .DATA_WIDTH_MAC(DW), .MXU_LATENCY(2), .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .vec_count(vec_count), .wm_base(wm_base),
        .busy(busy), .done(done), .wm_address(wm_address), .wm_ce(wm_ce), .wm_we(wm_we),
        .wm_dout(wm_dout), .infifo_dout(infifo_dout), .infifo_is_empty(infifo_is_empty),
        .infifo_read(infifo_read), .outfifo_din(outfifo_din), .outfifo_is_full(outfifo_is_full),
        .outfifo_write(outfifo_write), .mxu_enable(mxu_enable), .mxu_input(mxu_input),
        .mxu_weight(mxu_weight), .mxu_y(mxu_y), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] dot(input logic [KW-1:0] x, input logic [M*KW-1:0] w);
        logic [MW-1:0] y;
        logic [DW-1:0] acc;
        y = '0;
        for (int m = 0; m < M; m++) begin
            acc = '0;
            for (int k = 0; k < K; k++) begin
                acc = acc + DW'(x[k*DW +: DW] * w[(m*K+k)*DW +: DW]);
            end
            y[m*DW +: DW] = acc;
        end
        return y;
    endfunction

    // MXU stand-in: one register stage after the DUT's operand register.
    always @(posedge clk) begin
        if (mxu_enable) mxu_y <= dot(mxu_input, mxu_weight);
    end

    // Weight BRAM: garbage in upper bits must be ignored by the DUT.
    always @(posedge clk) begin
        if (wm_ce) begin
            case (wm_address)
                32'h40:  wm_dout <= 64'hFFFF_0000_0000_0123;
                32'h48:  wm_dout <= 64'hABCD_0000_0000_0456;
                32'h50:  wm_dout <= 64'h0000_0001_0000_0789;
                default: wm_dout <= 64'hFFFF_FFFF_FFFF_FFFF;
            endcase
        end
    end

    assign infifo_dout     = in_mem[in_rd[4:0]];
    assign infifo_is_empty = (in_rd == in_wr) || empty_gate;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_flush)                             in_rd <= in_wr;
        else if (infifo_read && !infifo_is_empty) in_rd <= in_rd + 1;
    end

    always @(negedge clk) begin
        if (start && !busy) start_cyc = cyc;
        if (done) begin done_cyc = cyc; done_cnt++; end
        if (infifo_read) rd_n++;
        if (infifo_read && infifo_is_empty) viol++;
        if (outfifo_write && outfifo_is_full) viol++;
        if (wm_we) viol++;
        if (outfifo_write) begin
            if (out_n < 32) out_log[out_n] = outfifo_din;
            out_n++;
        end
        if (wm_ce) begin
            if (wa_n < 8) wa_log[wa_n] = wm_address;
            wa_n++;
        end
        if (int'(dut.obuf_cnt_q) > obuf_max) obuf_max = int'(dut.obuf_cnt_q);
    end

    task automatic clear_mon();
        done_cnt = 0; rd_n = 0; out_n = 0; wa_n = 0; viol = 0; obuf_max = 0;
    endtask

    task automatic push(input logic [63:0] v);
        in_mem[in_wr[4:0]] = v;
        in_wr++;
    endtask

    task automatic flush();
        @(posedge clk); #1; in_flush = 1'b1;
        @(posedge clk); #1; in_flush = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [31:0] base);
        @(posedge clk); #1;
        vec_count = n; wm_base = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (wm_ce !== 1'b0)         begin errors++; $display("FAIL rst_wm_ce: got %b want 0", wm_ce); end
        checks++; if (wm_address !== 32'd0)   begin errors++; $display("FAIL rst_wm_address: got %h want 0", wm_address); end
        checks++; if (infifo_read !== 1'b0)   begin errors++; $display("FAIL rst_infifo_read: got %b want 0", infifo_read); end
        checks++; if (outfifo_write !== 1'b0) begin errors++; $display("FAIL rst_outfifo_write: got %b want 0", outfifo_write); end
        checks++; if (outfifo_din !== 64'd0)  begin errors++; $display("FAIL rst_outfifo_din: got %h want 0", outfifo_din); end
        checks++; if (mxu_enable !== 1'b0)    begin errors++; $display("FAIL rst_mxu_enable: got %b want 0", mxu_enable); end
        checks++; if (mxu_input !== '0)       begin errors++; $display("FAIL rst_mxu_input: got %h want 0", mxu_input); end
        checks++; if (mxu_weight !== '0)      begin errors++; $display("FAIL rst_mxu_weight: got %h want 0", mxu_weight); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_basic();
        clear_mon();
        for (int i = 0; i < 4; i++) push(64'h111);
        do_start(16'd4, 32'h40);
        wait_done(100);
        checks++; if (wa_n !== 3)               begin errors++; $display("FAIL basic_reads: got %0d want 3", wa_n); end
        checks++; if (wa_log[0] !== 32'h40)     begin errors++; $display("FAIL basic_addr0: got %h want 40", wa_log[0]); end
        checks++; if (wa_log[1] !== 32'h48)     begin errors++; $display("FAIL basic_addr1: got %h want 48", wa_log[1]); end
        checks++; if (wa_log[2] !== 32'h50)     begin errors++; $display("FAIL basic_addr2: got %h want 50", wa_log[2]); end
        checks++; if (mxu_weight !== 36'h789456123) begin errors++; $display("FAIL basic_weight: got %h want 789456123", mxu_weight); end
        checks++; if (rd_n !== 4)               begin errors++; $display("FAIL basic_infifo_reads: got %0d want 4", rd_n); end
        checks++; if (out_n !== 4)              begin errors++; $display("FAIL basic_writes: got %0d want 4", out_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_log[i] !== 64'h8F6) begin errors++; $display("FAIL basic_out%0d: got %h want 8f6", i, out_log[i]); end
        end
        checks++; if (done_cyc - start_cyc !== 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", done_cyc - start_cyc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL basic_idle: busy %b want 0", busy); end
        checks++; if (done_cnt !== 1)           begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_vec();
        clear_mon();
        push(64'h111);
        do_start(16'd0, 32'h40);
        wait_done(50);
        @(negedge clk);
        checks++; if (wa_n !== 3)    begin errors++; $display("FAIL zero_reads: got %0d want 3", wa_n); end
        checks++; if (rd_n !== 0)    begin errors++; $display("FAIL zero_infifo_reads: got %0d want 0", rd_n); end
        checks++; if (out_n !== 0)   begin errors++; $display("FAIL zero_writes: got %0d want 0", out_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle: busy %b want 0", busy); end
        flush();
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_tab [10];
        exp_tab[0] = 12'h963; exp_tab[1] = 12'h2C6; exp_tab[2] = 12'hB29; exp_tab[3] = 12'h48C;
        exp_tab[4] = 12'hDEF; exp_tab[5] = 12'h642; exp_tab[6] = 12'hFA5; exp_tab[7] = 12'h808;
        exp_tab[8] = 12'h16B; exp_tab[9] = 12'hACE;
        clear_mon();
        for (int i = 1; i <= 10; i++) push(64'(i));
        outfifo_is_full = 1'b1;
        do_start(16'd10, 32'h40);
        repeat (19) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_n !== OBUF_DEPTH) begin errors++; $display("FAIL bp_issued: got %0d want %0d", rd_n, OBUF_DEPTH); end
        checks++; if (out_n !== 0)         begin errors++; $display("FAIL bp_no_write: got %0d want 0", out_n); end
        checks++; if (obuf_max !== OBUF_DEPTH) begin errors++; $display("FAIL bp_buffer_fill: got %0d want %0d", obuf_max, OBUF_DEPTH); end
        @(posedge clk); #1;
        outfifo_is_full = 1'b0;
        wait_done(200);
        checks++; if (out_n !== 10) begin errors++; $display("FAIL bp_writes: got %0d want 10", out_n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_log[i] !== 64'(exp_tab[i])) begin errors++; $display("FAIL bp_out%0d: got %h want %h", i, out_log[i], exp_tab[i]); end
        end
        checks++; if (viol !== 0)           begin errors++; $display("FAIL bp_protocol: got %0d violations want 0", viol); end
        checks++; if (obuf_max > OBUF_DEPTH) begin errors++; $display("FAIL bp_overflow: got %0d want <= %0d", obuf_max, OBUF_DEPTH); end
    endtask

    task automatic test_empty_toggle();
        int d0;
        clear_mon();
        for (int i = 0; i < 6; i++) push(64'h111);
        do_start(16'd6, 32'h40);
        d0 = done_cnt;
        for (int n = 1; n <= 80 && done_cnt == d0; n++) begin
            empty_gate = (n % 2 == 1);
            @(posedge clk); #1;
        end
        empty_gate = 1'b0;
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL tog_done: got none want 1"); end
        checks++; if (rd_n !== 6)     begin errors++; $display("FAIL tog_reads: got %0d want 6", rd_n); end
        checks++; if (viol !== 0)     begin errors++; $display("FAIL tog_protocol: got %0d violations want 0", viol); end
        checks++; if (out_n !== 6)    begin errors++; $display("FAIL tog_writes: got %0d want 6", out_n); end
        checks++; if (out_log[5] !== 64'h8F6) begin errors++; $display("FAIL tog_out5: got %h want 8f6", out_log[5]); end
`ifdef DTPU_STALL_CNT_EN
        checks++; if (stall_cycles !== 32'd6) begin errors++; $display("FAIL tog_stall: got %0d want 6", stall_cycles); end
`else
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL tog_stall: got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int i = 0; i < 10; i++) push(64'h111);
        do_start(16'd10, 32'h40);
        repeat (6) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (infifo_read !== 1'b0)   begin errors++; $display("FAIL mid_infifo_read: got %b want 0", infifo_read); end
        checks++; if (outfifo_write !== 1'b0) begin errors++; $display("FAIL mid_outfifo_write: got %b want 0", outfifo_write); end
        checks++; if (outfifo_din !== 64'd0)  begin errors++; $display("FAIL mid_outfifo_din: got %h want 0", outfifo_din); end
        checks++; if (mxu_enable !== 1'b0)    begin errors++; $display("FAIL mid_mxu_enable: got %b want 0", mxu_enable); end
        checks++; if (mxu_input !== '0)       begin errors++; $display("FAIL mid_mxu_input: got %h want 0", mxu_input); end
        checks++; if (mxu_weight !== '0)      begin errors++; $display("FAIL mid_mxu_weight: got %h want 0", mxu_weight); end
        checks++; if (wm_address !== 32'd0)   begin errors++; $display("FAIL mid_wm_address: got %h want 0", wm_address); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt !== 0)         begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
        flush();
        clear_mon();
        for (int i = 0; i < 4; i++) push(64'h111);
        do_start(16'd4, 32'h40);
        wait_done(100);
        checks++; if (out_n !== 4)            begin errors++; $display("FAIL mid_restart_writes: got %0d want 4", out_n); end
        checks++; if (out_log[3] !== 64'h8F6) begin errors++; $display("FAIL mid_restart_out: got %h want 8f6", out_log[3]); end
    endtask

    task automatic test_start_ignored();
        clear_mon();
        for (int i = 0; i < 9; i++) push(64'h111);
        do_start(16'd5, 32'h40);
        repeat (5) @(posedge clk);
        #1; vec_count = 16'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(100);
        repeat (6) @(negedge clk);
        checks++; if (rd_n !== 5)     begin errors++; $display("FAIL ign_reads: got %0d want 5", rd_n); end
        checks++; if (out_n !== 5)    begin errors++; $display("FAIL ign_writes: got %0d want 5", out_n); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL ign_idle: busy %b want 0", busy); end
        flush();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_vec();
        test_backpressure();
        test_empty_toggle();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
